pipe_arbiter: RTL and testbench
===============================

PIPE_ARBITER -- requirements
Module: pipe_arbiter

Interface
REQ-001 Parameter W_DATA, default 32, width of each data beat.
REQ-002 Parameter N_REQ, default 4, number of requesters; legal range 2..16.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant; legal range 1..256.
REQ-004 i_clk  input  1  clock; all state updates on the rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 i_req_valid  input  N_REQ  per-requester beat valid.
REQ-007 i_req_data  input  N_REQ*W_DATA  per-requester data; requester k occupies bits [k*W_DATA +: W_DATA].
REQ-008 i_req_last  input  N_REQ  per-requester end-of-burst marker.
REQ-009 o_req_ready  output  N_REQ  per-requester beat accept.
REQ-010 o_valid  output  1  shared pipe beat valid.
REQ-011 o_data  output  W_DATA  shared pipe data.
REQ-012 o_last  output  1  shared pipe end-of-burst marker.
REQ-013 i_ready  input  1  shared pipe accept.
REQ-014 o_grant  output  N_REQ  one-hot current owner; all zero when idle.
REQ-015 o_busy  output  1  high while a grant is held.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE and OWN.
REQ-017 In IDLE, if any i_req_valid bit is high, the block SHALL select the first valid requester at or after rr_ptr, searching upward with wrap-around, and enter OWN on the next edge with o_grant set to that requester.
REQ-018 The grant decision SHALL be registered: the first beat is transferable one cycle after the request is seen in IDLE; no beat transfers in IDLE.
REQ-019 In OWN, with owner g: o_valid=i_req_valid[g], o_data=i_req_data[g], o_req_ready[g]=i_ready, and all other o_req_ready bits SHALL be 0.
REQ-020 A beat SHALL transfer when o_valid and i_ready are both high; beat_cnt SHALL increment per transfer.
REQ-021 o_last SHALL equal i_req_last[g] OR (beat_cnt==MAX_BURST-1), gated by o_valid.
REQ-022 On a transfer with o_last high, the block SHALL return to IDLE, clear o_grant, clear beat_cnt, and set rr_ptr=(g+1) mod N_REQ.
REQ-023 A transfer truncated by MAX_BURST SHALL release the grant even if i_req_last[g] is low; the requester keeps its remaining beats for a later grant.
REQ-024 If the owner drops i_req_valid mid-burst, the grant SHALL be held, with no timeout.
REQ-025 o_busy SHALL be high exactly when the state is OWN.
REQ-026 rr_ptr SHALL be $clog2(N_REQ) bits wide, and wrap from N_REQ-1 to 0 for non-power-of-two N_REQ.
REQ-027 beat_cnt SHALL be $clog2(MAX_BURST+1) bits wide and never exceed MAX_BURST-1.
REQ-028 Requests from non-owners SHALL be ignored during OWN; they are not latched.

Reset
REQ-029 Asserting resetn low SHALL, asynchronously, force state=IDLE, rr_ptr=0, beat_cnt=0, and o_grant=0.
REQ-030 Asserting resetn low SHALL also drive o_busy=0, o_valid=0, o_last=0, o_req_ready=0, and o_data=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration SHALL restart from requester 0.

Structure
REQ-032 The FSM state encoding and the arbiter parameter defaults SHALL live in the shared package pipe_pkg.
REQ-033 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector and rr_ptr; outputs: one-hot pick and any-valid).
REQ-034 All remaining logic (FSM, counters, and data mux) SHALL reside in pipe_arbiter.

Verification
REQ-035 Scenario: N_REQ=4; requesters 1 and 3 valid at once after reset, each with a 2-beat burst and i_ready=1 -> grant 1 first (2 beats), then IDLE for 1 cycle, then grant 3.
REQ-036 Scenario: requester 2 holds a 6-beat burst with last on beat 6 and MAX_BURST=4 -> o_last on beat 4, release, then regrant to 2 if it is the only requester, and o_last on beat 6.
REQ-037 Scenario: owner 0 with i_ready toggling 1,0,1,0 -> beats transfer only on i_ready=1 cycles; o_data is stable while stalled; beat_cnt increments only on transfers.
REQ-038 Scenario: owner 1 drops i_req_valid for 5 cycles mid-burst -> o_grant stays 4'b0010, o_valid=0, and no other requester receives ready.
REQ-039 Scenario: resetn pulsed low during beat 2 of a burst to requester 3 -> outputs go to zero immediately; after release with requesters 0 and 3 valid, requester 0 is granted first.
REQ-040 Scenario: all 4 requesters continuously valid with single-beat bursts -> grant order 0,1,2,3,0, each grant separated by one IDLE cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe arbiter: FSM state encoding and parameter defaults.
// Sub-modules import this package so defaults stay consistent across the slice.
package pipe_pkg;

  localparam int PIPE_W_DATA_DEF    = 32;
  localparam int PIPE_N_REQ_DEF     = 4;
  localparam int PIPE_MAX_BURST_DEF = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } pipe_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// searching upward and wrapping from N_REQ-1 back to 0.
module rr_pick
  import pipe_pkg::*;
#(
  parameter int N_REQ = PIPE_N_REQ_DEF,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_any
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Explicit wrap keeps the walk inside 0..N_REQ-1 for non-power-of-two counts.
  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = i_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
      w_idx = (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin burst arbiter merging N_REQ valid/ready requesters onto one pipe.
// A grant is held for one burst (ended by last or MAX_BURST beats).
//
// state   | meaning
// ST_IDLE | no owner; any request is registered as a grant on the next edge
// ST_OWN  | r_grant owns the pipe until a beat with o_last transfers
module pipe_arbiter
  import pipe_pkg::*;
#(
  parameter int W_DATA    = PIPE_W_DATA_DEF,
  parameter int N_REQ     = PIPE_N_REQ_DEF,
  parameter int MAX_BURST = PIPE_MAX_BURST_DEF
) (
  input  logic                    i_clk,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*W_DATA-1:0] i_req_data,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_valid,
  output logic [W_DATA-1:0]       o_data,
  output logic                    o_last,
  input  logic                    i_ready,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  pipe_state_t      r_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [N_REQ-1:0] r_grant;
  logic             r_busy;

  logic [N_REQ-1:0]  w_pick;
  logic              w_any;
  logic [PTR_W-1:0]  w_owner;
  logic [W_DATA-1:0] w_data;
  logic              w_valid;
  logic              w_last;
  logic              w_xfer;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req  (i_req_valid),
    .i_ptr  (r_rr_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  always_comb begin
    w_owner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) w_owner = PTR_W'(i);
    end
  end

  // AND-OR mux: a zero grant (idle or in reset) forces o_data to zero.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_data = w_data | (i_req_data[i*W_DATA +: W_DATA] & {W_DATA{r_grant[i]}});
    end
  end

  assign w_valid = |(i_req_valid & r_grant);
  assign w_last  = w_valid & ((|(i_req_last & r_grant)) | (r_beat_cnt == CNT_TERM));
  assign w_xfer  = w_valid & i_ready;

  assign o_valid     = w_valid;
  assign o_data      = w_data;
  assign o_last      = w_last;
  assign o_req_ready = r_grant & {N_REQ{i_ready}};
  assign o_grant     = r_grant;
  assign o_busy      = r_busy;

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (w_xfer) begin
            if (w_last) begin
              r_grant    <= '0;
              r_busy     <= 1'b0;
              r_beat_cnt <= '0;
              r_rr_ptr   <= (w_owner == PTR_LAST) ? '0 : w_owner + 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_grant    <= '0;
          r_busy     <= 1'b0;
          r_beat_cnt <= '0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge i_clk) disable iff (!resetn) $onehot0(r_grant));
  a_busy_state:   assert property (@(posedge i_clk) disable iff (!resetn) r_busy == (r_state == ST_OWN));
  a_cnt_range:    assert property (@(posedge i_clk) disable iff (!resetn) r_beat_cnt <= CNT_TERM);

endmodule

// File: tb/tb_pipe_arbiter.sv
// Randomized bench for pipe_arbiter: a transaction-level model predicts each
// transferred beat into a queue; a negedge monitor pops and compares.
module tb_pipe_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           i_clk = 1'b0;
  logic           resetn = 1'b0;
  logic [N-1:0]   i_req_valid;
  logic [N*W-1:0] i_req_data;
  logic [N-1:0]   i_req_last;
  logic [N-1:0]   o_req_ready;
  logic           o_valid;
  logic [W-1:0]   o_data;
  logic           o_last;
  logic           i_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;

  always #5 i_clk = ~i_clk;

  pipe_arbiter #(.W_DATA(W), .N_REQ(N), .MAX_BURST(MB)) dut (
    .i_clk       (i_clk),
    .resetn      (resetn),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_last      (o_last),
    .i_ready     (i_ready),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  typedef struct {
    int         owner;
    logic [W-1:0] data;
    bit         last;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_beats = 0;

  // Model: owner index (-1 = nobody), next search start, beats done in this grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  int           rem [N];
  logic [W-1:0] cur [N];
  int           ready_pct = 100;

  logic [N-1:0] exp_grant, exp_ready;
  bit           exp_busy, exp_valid, exp_last;
  bit           chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_grant"}, W'(o_grant), '0);
    check({tag, "_busy"},  W'(o_busy), '0);
    check({tag, "_valid"}, W'(o_valid), '0);
    check({tag, "_last"},  W'(o_last), '0);
    check({tag, "_ready"}, W'(o_req_ready), '0);
    check({tag, "_data"},  o_data, '0);
  endtask

  // Apply this cycle's inputs; predict what the pipe must show before the next edge.
  task automatic drive(input logic [N-1:0] force_v);
    for (int k = 0; k < N; k++) begin
      if (force_v[k] && rem[k] < 2) rem[k] = 2;
      if (rem[k] == 0 && $urandom_range(0, 3) == 0) rem[k] = int'($urandom_range(1, 7));
      i_req_valid[k]        = (rem[k] > 0) && (force_v[k] || $urandom_range(0, 9) != 0);
      i_req_last[k]         = (rem[k] == 1);
      i_req_data[k*W +: W]  = cur[k];
    end
    i_ready = (int'($urandom_range(1, 100)) <= ready_pct);
    if (m_owner >= 0) begin
      exp_grant = N'(1) << m_owner;
      exp_busy  = 1'b1;
      exp_valid = i_req_valid[m_owner];
      exp_last  = exp_valid && (i_req_last[m_owner] || m_cnt == MB - 1);
      exp_ready = i_ready ? exp_grant : '0;
      if (exp_valid && i_ready) exp_q.push_back('{m_owner, cur[m_owner], exp_last});
    end else begin
      exp_grant = '0;
      exp_busy  = 1'b0;
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      exp_ready = '0;
    end
  endtask

  // Advance the model across a rising edge using the inputs held during the cycle.
  task automatic step_model();
    bit lastf;
    if (m_owner >= 0) begin
      if (i_req_valid[m_owner] && i_ready) begin
        lastf = i_req_last[m_owner] || (m_cnt == MB - 1);
        rem[m_owner]--;
        cur[m_owner] = $urandom;
        n_beats++;
        if (lastf) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end
    end else if (i_req_valid != '0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && i_req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
    end
  endtask

  always @(negedge i_clk) begin
    beat_t b;
    if (chk_en) begin
      check("grant", W'(o_grant), W'(exp_grant));
      check("busy",  W'(o_busy), W'(exp_busy));
      check("valid", W'(o_valid), W'(exp_valid));
      check("last",  W'(o_last), W'(exp_last));
      check("req_ready", W'(o_req_ready), W'(exp_ready));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL xfer: DUT moved beat %0h, model expected none at %0t", o_data, $time);
        end else begin
          b = exp_q.pop_front();
          check("beat_data",  o_data, b.data);
          check("beat_owner", W'(o_grant), W'(N'(1) << b.owner));
          check("beat_last",  W'(o_last), W'(b.last));
        end
      end else if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL xfer: no beat moved, model expected %0h from req %0d at %0t",
                 b.data, b.owner, $time);
      end
    end
  end

  initial begin
    bit did_rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      rem[k] = 0;
      cur[k] = $urandom;
    end
    i_req_valid = '1;
    i_req_last  = '1;
    i_req_data  = {$urandom, $urandom, $urandom, $urandom};
    i_ready     = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check_zero_outputs("por");
    #1 resetn = 1'b1;
    drive('0);
    chk_en = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge i_clk);
      step_model();
      #1;
      if (cyc == 800)  ready_pct = 70;
      if (cyc == 1800) ready_pct = 40;
      if (!did_rst && cyc >= 1200 && ((m_owner >= 0 && m_cnt >= 1) || cyc == 1700)) begin
        did_rst = 1'b1;
        chk_en  = 1'b0;
        resetn  = 1'b0;
        #1;
        check_zero_outputs("midrst");
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        exp_q.delete();
        @(posedge i_clk);
        #1;
        check_zero_outputs("inrst");
        #1 resetn = 1'b1;
        drive(4'b1001);
        chk_en = 1'b1;
      end else begin
        drive('0);
      end
    end

    @(negedge i_clk);
    #1 chk_en = 1'b0;
    check("queue_drained", W'(exp_q.size()), '0);
    check("beats_moved", W'(n_beats > 500), W'(1));
    check("reset_injected", W'(did_rst), W'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
